// File: rtl/filter_table_if.sv
// Register-access bus for the coefficient table controller.
// The master issues a request held until the slave pulses acc_ready.
interface filter_table_if;
  logic        acc_valid;
  logic        acc_write;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_ready;
  logic [31:0] acc_rdata;
  logic        acc_err;

  modport master (
    output acc_valid, acc_write, acc_addr, acc_wdata,
    input  acc_ready, acc_rdata, acc_err
  );

  modport slave (
    input  acc_valid, acc_write, acc_addr, acc_wdata,
    output acc_ready, acc_rdata, acc_err
  );
endinterface

// File: rtl/filter_table_ctrl.sv
// Coefficient table controller: arbitrates a single-port RAM between register access and the
// filter core. Optional macro FILTER_TABLE_ERR_EN enables acc_err reporting.
module filter_table_ctrl #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  filter_table_if.slave            acc,
  input  logic                     direct,
  input  logic                     filt_cs,
  input  logic [$clog2(DEPTH)-1:0] filt_addr,
  output logic [DATA_W-1:0]        filt_rdata,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [31:0]     wdata_q;
  logic [1:0]      cnt_q;
  logic            ram_rd_q, rd_ptr_q, ld_ptr_q, inc_q, dec_q, err_q;

  logic            accept;
  logic            is_ptr, is_wreg, is_rreg;
  logic            go_wr, go_rd;
  logic            ram_rd_d, rd_ptr_d, ld_ptr_d, inc_d, dec_d, err_d;

  // Request decode; everything the access needs is captured at acceptance.
  always_comb begin
    accept  = (state_q == StIdle) && acc.acc_valid;
    is_ptr  = (acc.acc_addr == 8'h44);
    is_wreg = acc.acc_addr inside {8'h48, 8'h4C, 8'h50};
    is_rreg = acc.acc_addr inside {8'h54, 8'h58, 8'h5C};
    go_wr   = acc.acc_write && direct && is_wreg;
    go_rd   = !acc.acc_write && direct && is_rreg;
    ram_rd_d = go_rd;
    rd_ptr_d = !acc.acc_write && is_ptr;
    inc_d    = (go_wr && acc.acc_addr == 8'h4C) || (go_rd && acc.acc_addr == 8'h58);
    dec_d    = (go_wr && acc.acc_addr == 8'h50) || (go_rd && acc.acc_addr == 8'h5C);
`ifdef FILTER_TABLE_ERR_EN
    ld_ptr_d = acc.acc_write && is_ptr && (acc.acc_wdata < 32'(DEPTH));
    err_d    = ((is_wreg || is_rreg) && !direct) ||
               (acc.acc_write && is_ptr && (acc.acc_wdata >= 32'(DEPTH)));
`else
    ld_ptr_d = acc.acc_write && is_ptr;
    err_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (go_wr)      state_d = StWr;
          else if (go_rd) state_d = StRd;
          else            state_d = StDone;
        end
      end
      StWr:   state_d = StDone;
      StRd:   if (cnt_q == 2'(RD_LAT - 1)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pointer moves only at the end of DONE; DEPTH is a power of two so wrap is free.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StDone) begin
      if (ld_ptr_q)   ptr_d = AW'(wdata_q % DEPTH);
      else if (inc_q) ptr_d = ptr_q + 1'b1;
      else if (dec_q) ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ram_rd_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ld_ptr_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= (state_q == StRd) ? cnt_q + 2'd1 : 2'd0;
      if (accept) begin
        wdata_q  <= acc.acc_wdata;
        ram_rd_q <= ram_rd_d;
        rd_ptr_q <= rd_ptr_d;
        ld_ptr_q <= ld_ptr_d;
        inc_q    <= inc_d;
        dec_q    <= dec_d;
        err_q    <= err_d;
      end
    end
  end

  // RAM read data is valid exactly in the DONE cycle, so it is forwarded, not registered.
  always_comb begin
    acc.acc_ready = (state_q == StDone);
    acc.acc_err   = (state_q == StDone) && err_q;
    acc.acc_rdata = '0;
    if (state_q == StDone) begin
      if (ram_rd_q)      acc.acc_rdata = 32'(ram_rdata);
      else if (rd_ptr_q) acc.acc_rdata = 32'(ptr_q);
    end
  end

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (!direct) begin
          ram_cs   = filt_cs;
          ram_addr = filt_addr;
        end
      end
      StWr: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = ptr_q;
        ram_wdata = wdata_q[DATA_W-1:0];
      end
      StRd: begin
        ram_cs   = (cnt_q == 2'd0);
        ram_addr = ptr_q;
      end
      default: ;
    endcase
  end

  assign filt_rdata = ram_rdata;

endmodule

// File: doc/filter_table_ctrl.md
FILTER_TABLE_CTRL -- requirements
Module: filter_table_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256: coefficient table depth in words (power of two, 2..256).
REQ-002 SHALL have parameter DATA_W, default 24: table word width.
REQ-003 SHALL have parameter RD_LAT, default 1: RAM read latency in cycles (1..3).
REQ-004 SHALL have port clk  in  1: the single clock.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port acc_valid  in  1: table register access request, held until acc_ready.
REQ-007 SHALL have port acc_write  in  1: 1 = write, 0 = read.
REQ-008 SHALL have port acc_addr  in  8: register offset, one of 0x44, 0x48, 0x4C, 0x50, 0x54, 0x58, 0x5C.
REQ-009 SHALL have port acc_wdata  in  32: write data.
REQ-010 SHALL have ports acc_ready  out  1 and acc_rdata  out  32: completion pulse and read data; acc_rdata is valid with acc_ready.
REQ-011 SHALL have port acc_err  out  1: error flag, valid with acc_ready.
REQ-012 SHALL have port direct  in  1: TABLE_CFG.DIRECT; 1 gives bus ownership of the RAM, 0 gives the filter core ownership.
REQ-013 SHALL have ports filt_cs  in  1, filt_addr  in  $clog2(DEPTH) and filt_rdata  out  DATA_W: the filter core read port.
REQ-014 SHALL have ports ram_cs, ram_we  out  1; ram_addr  out  $clog2(DEPTH); ram_wdata  out  DATA_W; ram_rdata  in  DATA_W: the single-port RAM.

Function
REQ-015 SHALL hold an address pointer ptr that resets to 0.
- Write to 0x44 loads ptr = acc_wdata mod DEPTH.
- Read of 0x44 returns ptr, zero-extended.
REQ-016 SHALL use the FSM IDLE -> WR or RD -> DONE -> IDLE.
- IDLE accepts acc_valid.
- WR takes 1 cycle.
- RD lasts RD_LAT cycles.
- DONE asserts acc_ready for exactly 1 cycle.
REQ-017 SHALL complete writes to 0x48, 0x4C and 0x50 as follows:
- In WR: ram_cs = 1, ram_we = 1, ram_addr = ptr, ram_wdata = acc_wdata[DATA_W-1:0].
- acc_ready is asserted 2 cycles after acc_valid is sampled.
REQ-018 SHALL complete reads of 0x54, 0x58 and 0x5C as follows:
- ram_cs = 1, ram_we = 0, ram_addr = ptr in the first RD cycle.
- ram_rdata is captured after RD_LAT cycles and returned zero-extended.
- acc_ready is asserted RD_LAT+1 cycles after acceptance.
REQ-019 SHALL update ptr in the DONE cycle as follows:
- 0x4C and 0x58: ptr+1, wrapping DEPTH-1 -> 0.
- 0x50 and 0x5C: ptr-1, wrapping 0 -> DEPTH-1.
- 0x48 and 0x54: ptr unchanged.
REQ-020 SHALL handle the remaining access types as follows:
- Read of 0x48, 0x4C or 0x50 returns 0 with no RAM access.
- Write to 0x54, 0x58, 0x5C or an unlisted offset is ignored.
- All of these complete via DONE with acc_ready 1 cycle after acceptance.
REQ-021 SHALL sample direct at acceptance; a change of direct during WR, RD or DONE does not affect the access in flight.
REQ-022 SHALL, when the sampled direct = 0, give any data-register access (0x48..0x5C) no RAM cycle, read data 0, ptr unchanged, and acc_ready 1 cycle after acceptance.
REQ-023 SHALL ignore acc_valid in the DONE cycle; a new access is accepted no earlier than the cycle after DONE.
REQ-024 SHALL, while direct = 0 and the FSM is in IDLE, drive ram_cs = filt_cs, ram_we = 0 and ram_addr = filt_addr.
REQ-025 SHALL drive filt_rdata = ram_rdata at all times.
REQ-026 SHALL deassert ram_cs and ram_we whenever no access is active.

Reset
REQ-027 SHALL on rst_n low, asynchronously:
- enter IDLE;
- set ptr = 0;
- set acc_ready, acc_err, ram_cs and ram_we to 0;
- set acc_rdata, ram_addr and ram_wdata to 0.
REQ-028 SHALL drop an access in flight at reset with no acc_ready, and leave the RAM write aborted if reset is asserted before WR.

Configuration
REQ-029 SHALL use macro FILTER_TABLE_ERR_EN.
- Defined: acc_err = 1 with acc_ready for a data-register access while the sampled direct = 0.
- Defined: acc_err = 1 for a write to 0x44 with acc_wdata >= DEPTH; ptr is then unchanged.
- Undefined: acc_err is tied to 0 and those 0x44 writes load acc_wdata mod DEPTH.

Verification
REQ-030 SHALL cover: direct=1, write 0x44=0x10, then 0x4C=0xABCDEF -> RAM[0x10]=0xABCDEF, ptr=0x11, acc_ready 2 cycles after valid.
REQ-031 SHALL cover: ptr=0xFF, DEPTH=256, read 0x58 -> returns RAM[0xFF] at RD_LAT+1 cycles, ptr=0x00; then read 0x5C -> ptr=0xFF.
REQ-032 SHALL cover: direct=0, read 0x54 -> acc_rdata=0, no ram_cs from the bus path, acc_err=1 with FILTER_TABLE_ERR_EN and 0 without.
REQ-033 SHALL cover: write 0x44=0x100 with FILTER_TABLE_ERR_EN -> acc_err=1, ptr unchanged; without the macro -> ptr=0x00.
REQ-034 SHALL cover: rst_n low during RD -> no acc_ready, ptr=0, FSM in IDLE, next access completes normally.
REQ-035 SHALL cover: direct toggled 1->0 during a WR of 0x48 -> write completes, and filt_cs takes the RAM from the next IDLE cycle.
